dds_dac_spi_tx: RTL and testbench

// - Downstream stage of the DDS core in the DAC pcore: takes signed 10-bit sine samples, applies a gain, converts to offset binary, and shifts 16-bit frames to an external serial DAC.
// - One-entry holding register with valid/ready handshake decouples the DDS sample rate from the serial frame rate.

---
 rtl/dds_dac_spi_tx.sv | 253 +++++++++++++++++++++++++
 tb/tb_dds_dac_spi_tx.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_dac_spi_tx.sv
// ---------------------------------------------------------------------------
// dds_dac_spi_tx
//
// Output stage of the DDS core. It scales a signed 10-bit sine sample by an
// unsigned Q1.7 gain, converts the result to 12-bit offset binary and sends
// it to an external serial DAC as a 16-bit frame {CTRL, code12}, MSB first.
// A one-entry holding register with a valid/ready handshake lets the DDS run
// at its own sample rate. Samples offered while the register is full are
// dropped.
//
// Frame timing (one frame, CLK_DIV = clk cycles per SCLK half-period):
//   SETUP : CLK_DIV cycles, cs_n low, sclk low, first bit on din
//   SHIFT : 32 half-periods, sclk rises on entry and then toggles every
//           CLK_DIV cycles. din advances on each sclk fall.
//   HOLD  : CLK_DIV cycles, cs_n high
//   IDLE  : one cycle minimum, where the next frame is loaded
//
// Optional feature (macro DDS_DAC_MUTE_MIDSCALE_EN): when enable falls, one
// midscale frame {CTRL, 12'h800} is sent after any frame in flight.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   enable     in   1 = accept samples and start frames
//   gain[7:0]  in   amplitude scale, 128 = unity
//   in_valid   in   sample qualifier
//   in_sample  in   signed two's-complement sample [9:0]
//   in_ready   out  enable & hold register empty (combinational)
//   dac_cs_n   out  DAC chip select, active low
//   dac_sclk   out  serial clock, idle low
//   dac_din    out  serial data, changes after sclk falls
//   busy       out  frame in progress (or midscale frame pending)
// ---------------------------------------------------------------------------
module dds_dac_spi_tx #(
    parameter int          CLK_DIV = 4,
    parameter logic [3:0]  CTRL    = 4'h3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [7:0]  gain,
    input  logic        in_valid,
    input  logic [9:0]  in_sample,
    output logic        in_ready,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_din,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam int                 CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [4:0]         HALF_LAST = 5'd31;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        half_q, half_d;
    logic [15:0]       shift_q, shift_d;
    logic [11:0]       hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;
    logic              din_q, din_d;

    // ------------------------------------------------------------------
    // Sample scaling: 10b signed x 9b signed-positive gain -> 19b product.
    // The arithmetic shift floors toward minus infinity, then the result
    // is clamped to the 10-bit range before offset-binary conversion.
    // ------------------------------------------------------------------
    logic signed [18:0] prod;
    logic signed [18:0] scaled;
    logic signed [9:0]  sat;
    logic [11:0]        code12;

    always_comb begin
        prod   = $signed(in_sample) * $signed({1'b0, gain});
        scaled = prod >>> 7;
        if (scaled > 19'sd511) begin
            sat = 10'sd511;
        end else if (scaled < -19'sd512) begin
            sat = 10'h200;
        end else begin
            sat = scaled[9:0];
        end
        // Inverting the sign bit turns two's complement into offset binary.
        code12 = {~sat[9], sat[8:0], 2'b00};
    end

    assign in_ready = enable & ~hold_full_q;

    logic        capture;
    logic        start;
    logic [15:0] start_frame;
    logic        cnt_end;

`ifdef DDS_DAC_MUTE_MIDSCALE_EN
    localparam logic [11:0] MIDSCALE = 12'h800;
    logic enable_q, enable_d;
    logic mute_pend_q, mute_pend_d;
`endif

    always_comb begin
        // NOTE: every signal assigned here gets a default first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        half_d      = half_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        din_d       = din_q;
        start       = 1'b0;
        start_frame = {CTRL, hold_q};
        cnt_end     = (cnt_q == CNT_LAST);
        capture     = in_valid & in_ready;
`ifdef DDS_DAC_MUTE_MIDSCALE_EN
        enable_d    = enable;
        mute_pend_d = mute_pend_q;
`endif

        if (capture) begin
            hold_d      = code12;
            hold_full_d = 1'b1;
        end
        // A sample still waiting when enable drops is thrown away.
        if (!enable) begin
            hold_full_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
`ifdef DDS_DAC_MUTE_MIDSCALE_EN
                // The mute frame takes priority over any held sample.
                if (mute_pend_q) begin
                    start       = 1'b1;
                    start_frame = {CTRL, MIDSCALE};
                    mute_pend_d = 1'b0;
                end else
`endif
                if (hold_full_q && enable) begin
                    start       = 1'b1;
                    hold_full_d = 1'b0;
                end
            end
            ST_SETUP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_end) begin
                    cnt_d   = '0;
                    half_d  = '0;
                    sclk_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_end) begin
                    cnt_d = '0;
                    if (half_q == HALF_LAST) begin
                        // sclk is already low here: the 16th fall opened
                        // this last half-period.
                        cs_n_d  = 1'b1;
                        sclk_d  = 1'b0;
                        state_d = ST_HOLD;
                    end else begin
                        half_d = half_q + 1'b1;
                        sclk_d = ~sclk_q;
                        if (sclk_q) begin
                            din_d   = shift_q[15];
                            shift_d = {shift_q[14:0], 1'b0};
                        end
                    end
                end
            end
            default: begin // ST_HOLD
                cnt_d = cnt_q + 1'b1;
                if (cnt_end) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
        endcase

        if (start) begin
            state_d = ST_SETUP;
            cnt_d   = '0;
            cs_n_d  = 1'b0;
            din_d   = start_frame[15];
            shift_d = {start_frame[14:0], 1'b0};
        end

`ifdef DDS_DAC_MUTE_MIDSCALE_EN
        // Set after the clear so that a fresh drop is never lost.
        if (enable_q && !enable) begin
            mute_pend_d = 1'b1;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            half_q      <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            din_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            din_q       <= din_d;
        end
    end

`ifdef DDS_DAC_MUTE_MIDSCALE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q    <= 1'b0;
            mute_pend_q <= 1'b0;
        end else begin
            enable_q    <= enable_d;
            mute_pend_q <= mute_pend_d;
        end
    end

    assign busy = (state_q != ST_IDLE) | mute_pend_q;
`else
    assign busy = (state_q != ST_IDLE);
`endif

    assign dac_cs_n = cs_n_q;
    assign dac_sclk = sclk_q;
    assign dac_din  = din_q;

endmodule

// File: tb/tb_dds_dac_spi_tx.sv
// ---------------------------------------------------------------------------
// tb_dds_dac_spi_tx
//
// Self-checking bench for dds_dac_spi_tx (CLK_DIV = 4, CTRL = 4'h3).
// A negedge monitor reassembles each frame from the bits seen at sclk
// rising edges while cs_n is low, and records the frame's rise count, its
// cs_n-low length and its start/end cycles. Expected frames come from an
// arithmetic model of the scaling and offset-binary coding.
// Honours DDS_DAC_MUTE_MIDSCALE_EN for the enable-drop expectations.
// ---------------------------------------------------------------------------
module tb_dds_dac_spi_tx;

    localparam int         CLK_DIV = 4;
    localparam logic [3:0] CTRL    = 4'h3;
    localparam int         LOW_LEN = 33 * CLK_DIV;
    localparam int         PERIOD  = 34 * CLK_DIV + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] gain;
    logic       in_valid;
    logic [9:0] in_sample;
    logic       in_ready;
    logic       dac_cs_n;
    logic       dac_sclk;
    logic       dac_din;
    logic       busy;

    dds_dac_spi_tx #(.CLK_DIV(CLK_DIV), .CTRL(CTRL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .gain      (gain),
        .in_valid  (in_valid),
        .in_sample (in_sample),
        .in_ready  (in_ready),
        .dac_cs_n  (dac_cs_n),
        .dac_sclk  (dac_sclk),
        .dac_din   (dac_din),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: floor(sample*gain/128), clamp, add 512 for offset binary.
    function automatic logic [15:0] model_frame(input int sample, input int g);
        int p;
        int s;
        p = sample * g;
        if (p >= 0) s = p / 128;
        else        s = -((-p + 127) / 128);
        if (s > 511)  s = 511;
        if (s < -512) s = -512;
        return 16'((int'(CTRL) << 12) + (s + 512) * 4);
    endfunction

    // ---------------- frame monitor ----------------
    typedef struct {
        logic [15:0] bits;
        int          rises;
        int          low;
        int          t_start;
        int          t_end;
    } frame_t;

    frame_t mon_q[$];

    initial begin
        int          cyc = 0;
        logic        prev_cs = 1'b1;
        logic        prev_sclk = 1'b0;
        logic        in_frame = 1'b0;
        frame_t      cur;
        cur = '{bits: 16'h0, rises: 0, low: 0, t_start: 0, t_end: 0};
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                in_frame  = 1'b0;
                prev_cs   = 1'b1;
                prev_sclk = 1'b0;
            end else begin
                if (prev_cs && !dac_cs_n) begin
                    in_frame    = 1'b1;
                    cur.bits    = 16'h0;
                    cur.rises   = 0;
                    cur.low     = 0;
                    cur.t_start = cyc;
                end
                if (!dac_cs_n) begin
                    cur.low++;
                    if (dac_sclk && !prev_sclk) begin
                        cur.bits = {cur.bits[14:0], dac_din};
                        cur.rises++;
                    end
                end
                if (!prev_cs && dac_cs_n && in_frame) begin
                    cur.t_end = cyc;
                    mon_q.push_back(cur);
                    in_frame = 1'b0;
                end
                prev_cs   = dac_cs_n;
                prev_sclk = dac_sclk;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic send_one(input int sample, input int g);
        @(negedge clk);
        check("in_ready_before_offer", in_ready, 1);
        in_sample = 10'(sample);
        gain      = 8'(g);
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        check("in_ready_after_capture", in_ready, 0);
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        int k = 0;
        while (mon_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_frame_count"}, mon_q.size(), n);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic wait_cs_low(input string tag);
        int k = 0;
        while (dac_cs_n && k < 500) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_cs_start"}, dac_cs_n, 0);
    endtask

    task automatic check_next_frame(input string tag, input logic [15:0] exp);
        frame_t f;
        check({tag, "_present"}, (mon_q.size() > 0), 1);
        if (mon_q.size() > 0) begin
            f = mon_q.pop_front();
            check({tag, "_bits"}, f.bits, exp);
            check({tag, "_rises"}, f.rises, 16);
            check({tag, "_cs_low"}, f.low, LOW_LEN);
        end
    endtask

    // ---------------- directed tables ----------------
    int          dir_sample[6] = '{0, 511, -512, 300, -300, 200};
    int          dir_gain[6]   = '{128, 128, 128, 255, 255, 64};
    logic [15:0] dir_exp[6]    = '{16'h3800, 16'h3FFC, 16'h3000, 16'h3FFC, 16'h3000, 16'h3990};

    initial begin
        int          rs;
        int          rg;
        int          a_s, b_s, c_s;
        int          exp_n;
        logic [15:0] mid;

        mid       = {CTRL, 12'h800};
        rst_n     = 1'b0;
        enable    = 1'b0;
        gain      = 8'd128;
        in_valid  = 1'b0;
        in_sample = 10'd0;

        // Step 1: reset values.
        #17;
        check("rst_cs_n", dac_cs_n, 1);
        check("rst_sclk", dac_sclk, 0);
        check("rst_din", dac_din, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        // Step 2: directed coding and saturation.
        for (int i = 0; i < 6; i++) begin
            wait_idle("dir");
            send_one(dir_sample[i], dir_gain[i]);
            wait_frames("dir", 1, 600);
            check_next_frame($sformatf("dir%0d", i), dir_exp[i]);
        end

        // Step 3: random samples and gains against the model.
        for (int i = 0; i < 10; i++) begin
            rs = int'($urandom_range(0, 1023)) - 512;
            rg = int'($urandom_range(0, 255));
            wait_idle("rnd");
            send_one(rs, rg);
            wait_frames("rnd", 1, 600);
            check_next_frame($sformatf("rnd%0d", i), model_frame(rs, rg));
        end

        // Step 4: back-to-back timing with in_valid held high.
        wait_idle("b2b");
        mon_q.delete();
        rs        = int'($urandom_range(0, 1023)) - 512;
        rg        = int'($urandom_range(0, 255));
        in_sample = 10'(rs);
        gain      = 8'(rg);
        in_valid  = 1'b1;
        wait_frames("b2b", 3, 800);
        in_valid  = 1'b0;
        if (mon_q.size() >= 3) begin
            check("b2b_gap", mon_q[1].t_start - mon_q[0].t_end, CLK_DIV + 1);
            check("b2b_period", mon_q[2].t_start - mon_q[1].t_start, PERIOD);
        end
        for (int i = 0; i < 3; i++) begin
            check_next_frame($sformatf("b2b%0d", i), model_frame(rs, rg));
        end
        repeat (400) @(negedge clk);
        wait_idle("b2b_drain");
        mon_q.delete();

        // Step 5: hold register refills mid-frame; an offer while full drops.
        a_s = int'($urandom_range(0, 1023)) - 512;
        b_s = int'($urandom_range(0, 1023)) - 512;
        c_s = int'($urandom_range(0, 1023)) - 512;
        send_one(a_s, 128);
        wait_cs_low("refill");
        repeat (20) @(negedge clk);
        send_one(b_s, 128);
        in_sample = 10'(c_s);
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        repeat (500) @(negedge clk);
        check("refill_frame_count", mon_q.size(), 2);
        check_next_frame("refill_a", model_frame(a_s, 128));
        check_next_frame("refill_b", model_frame(b_s, 128));
        wait_idle("refill");
        mon_q.delete();

        // Step 6: enable drops mid-frame.
        rs        = int'($urandom_range(0, 1023)) - 512;
        in_sample = 10'(rs);
        gain      = 8'd128;
        in_valid  = 1'b1;
        wait_cs_low("drop");
        repeat (40) @(negedge clk);
        enable    = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("drop_in_ready", in_ready, 0);
        repeat (400) @(negedge clk);
`ifdef DDS_DAC_MUTE_MIDSCALE_EN
        exp_n = 2;
`else
        exp_n = 1;
`endif
        check("drop_frame_count", mon_q.size(), exp_n);
        check("drop_busy", busy, 0);
        check_next_frame("drop_inflight", model_frame(rs, 128));
`ifdef DDS_DAC_MUTE_MIDSCALE_EN
        check_next_frame("drop_mute", mid);
`endif
        // The sample held at the drop was discarded: nothing follows.
        enable = 1'b1;
        repeat (300) @(negedge clk);
        check("drop_discard", mon_q.size(), 0);
        mon_q.delete();

        // Step 7: reset pulsed mid-SHIFT.
        rs = int'($urandom_range(0, 1023)) - 512;
        send_one(rs, 128);
        wait_cs_low("mrst");
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_cs_n", dac_cs_n, 1);
        check("mrst_sclk", dac_sclk, 0);
        check("mrst_din", dac_din, 0);
        check("mrst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("mrst_no_partial", mon_q.size(), 0);
        rs = int'($urandom_range(0, 1023)) - 512;
        rg = int'($urandom_range(0, 255));
        send_one(rs, rg);
        wait_frames("mrst", 1, 600);
        check_next_frame("mrst_after", model_frame(rs, rg));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
